param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo_pkg.sv | 16 +
 rtl/param_fifo_mem.sv | 31 +++
 rtl/param_fifo.sv | 109 ++++++++++
 tb/tb_param_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
// Shared constants and width helpers for the parameterised FIFO.
// Widths: pointer = clog2(depth), count = clog2(depth)+1.
package param_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// fifo_mem: 1W/1R register array, synchronous write, registered read.
// Read register resets to 0 and holds when rd_en is low.
module fifo_mem
  import param_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO: pointers, count, flags, optional sticky errors.
// Define PARAM_FIFO_ERR_EN to build overflow/underflow tracking.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wren,
  input  logic                     rden,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  input  logic                     clr_err,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          wr_acc;
  logic          rd_acc;

  assign full         = (cnt == CW'(DEPTH));
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= CW'(AF_LVL));
  assign almost_empty = (cnt <= CW'(AE_LVL));
  assign count        = cnt;

  // A read frees a slot in the same edge, so full+rden still writes.
  assign wr_acc = wren & (~full | rden);
  assign rd_acc = rden & ~empty;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (i_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (o_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        wr_acc & ~rd_acc: cnt <= cnt + CW'(1);
        rd_acc & ~wr_acc: cnt <= cnt - CW'(1);
        default:          cnt <= cnt;
      endcase
    end
  end

`ifdef PARAM_FIFO_ERR_EN
  logic ovf_set;
  logic unf_set;

  assign ovf_set = wren & full & ~rden;
  assign unf_set = rden & empty;

  // Set wins over clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_err;
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo (W=8, D=8, AF=6, AE=2).
// Error-flag expectations follow whether PARAM_FIFO_ERR_EN is defined.
module tb_param_fifo;

`ifdef PARAM_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wren = 1'b0;
  logic       rden = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] i_data = '0;
  logic [7:0] o_data;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  param_fifo #(
    .WIDTH  (8),
    .DEPTH  (8),
    .AF_LVL (6),
    .AE_LVL (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wren         (wren),
    .rden         (rden),
    .i_data       (i_data),
    .o_data       (o_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .clr_err      (clr_err),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_odata", 32'(o_data), 0);
    chk("rst_ae",    32'(almost_empty), 1);
    chk("rst_af",    32'(almost_full), 0);
    chk("rst_full",  32'(full), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_unf",   32'(underflow), 0);
    step;
    rst = 1'b0;
    step;

    // fill with walking ones
    for (int i = 0; i < 8; i++) begin
      wren   = 1'b1;
      i_data = 8'(1 << i);
      step;
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_ae",    32'(almost_empty), 32'(i + 1 <= 2));
      chk("fill_af",    32'(almost_full), 32'(i + 1 >= 6));
      chk("fill_full",  32'(full), 32'(i == 7));
    end
    chk("fill_ovf", 32'(overflow), 0);

    // dropped write while full
    i_data = 8'hAA;
    step;
    wren = 1'b0;
    chk("drop_count", 32'(count), 8);
    chk("drop_ovf",   32'(overflow), 32'(ERR));

    for (int i = 0; i < 8; i++) begin
      rden = 1'b1;
      step;
      chk("drain_data",  32'(o_data), 32'(1 << i));
      chk("drain_count", 32'(count), 32'(7 - i));
    end
    rden = 1'b0;
    chk("drain_empty", 32'(empty), 1);

    // read while empty
    rden = 1'b1;
    step;
    rden = 1'b0;
    chk("unf_set",   32'(underflow), 32'(ERR));
    chk("unf_odata", 32'(o_data), 32'h80);
    chk("unf_count", 32'(count), 0);
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("clr_unf", 32'(underflow), 0);
    chk("clr_ovf", 32'(overflow), 0);
    rden    = 1'b1;
    clr_err = 1'b1;
    step;
    rden    = 1'b0;
    clr_err = 1'b0;
    chk("set_beats_clr", 32'(underflow), 32'(ERR));
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("clr_unf2", 32'(underflow), 0);

    // simultaneous read/write while full
    for (int i = 0; i < 8; i++) begin
      wren   = 1'b1;
      i_data = 8'(8'h10 + i);
      step;
    end
    rden   = 1'b1;
    i_data = 8'h55;
    step;
    wren = 1'b0;
    chk("rw_full_data",  32'(o_data), 32'h10);
    chk("rw_full_count", 32'(count), 8);
    chk("rw_full_ovf",   32'(overflow), 0);
    for (int i = 1; i < 8; i++) begin
      step;
      chk("rw_drain", 32'(o_data), 32'(8'h10 + i));
    end
    step;
    rden = 1'b0;
    chk("rw_last",  32'(o_data), 32'h55);
    chk("rw_empty", 32'(empty), 1);

    // simultaneous read/write while empty
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    wren   = 1'b1;
    rden   = 1'b1;
    i_data = 8'h33;
    step;
    wren = 1'b0;
    rden = 1'b0;
    chk("rw_empty_count", 32'(count), 1);
    chk("rw_empty_odata", 32'(o_data), 32'h55);
    chk("rw_empty_unf",   32'(underflow), 32'(ERR));
    rden = 1'b1;
    step;
    rden = 1'b0;
    chk("rw_empty_rd", 32'(o_data), 32'h33);
    chk("rw_empty_c0", 32'(count), 0);

    // async reset mid-operation
    for (int i = 0; i < 5; i++) begin
      wren   = 1'b1;
      i_data = 8'(8'hA0 + i);
      step;
    end
    wren = 1'b0;
    chk("pre_rst_count", 32'(count), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_empty", 32'(empty), 1);
    chk("arst_count", 32'(count), 0);
    chk("arst_odata", 32'(o_data), 0);
    chk("arst_unf",   32'(underflow), 0);
    #2;
    rst = 1'b0;
    step;
    wren   = 1'b1;
    i_data = 8'h77;
    step;
    wren = 1'b0;
    chk("post_rst_count", 32'(count), 1);
    rden = 1'b1;
    step;
    rden = 1'b0;
    chk("post_rst_data", 32'(o_data), 32'h77);
    chk("post_rst_c0",   32'(count), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
